// File: rtl/sg13g2_cell_bist.sv
// sg13g2_cell_bist: LFSR-driven self test for a bank of cells, responses compacted into a 16-bit MISR.
// Latency: busy for 1+NPAT+DLY+1 cycles (SEED, RUN, DRAIN, CMP), then a one-cycle done pulse.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or done.
// Option: define SG13G2_BIST_SIG_OUT_EN to add output sig carrying the live MISR value.
module sg13g2_cell_bist #(
   parameter int unsigned NPAT = 255,
   parameter int unsigned DLY  = 1
) (
   input  logic        cp,
   input  logic        cd,
   input  logic        start,
   input  logic [15:0] exp,
   input  logic [7:0]  rsp,
   output logic [7:0]  pat,
   output logic        busy,
   output logic        done,
   output logic        pass
`ifdef SG13G2_BIST_SIG_OUT_EN
   ,
   output logic [15:0] sig
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEED  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      CMP   = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Terminal counts: the counter runs 0..N-1 in RUN and again 0..DLY-1 in DRAIN.
   localparam logic [15:0] NPAT_LAST = 16'(NPAT - 1);
   localparam logic [15:0] DLY_LAST  = 16'(DLY - 1);

   state_t           state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [15:0]      misr_q, misr_d;
   logic [7:0]       pat_q, pat_d;
   logic             pass_q, pass_d;
   logic [DLY-1:0]   vld_q, vld_d;

   logic [7:0]       lfsr_nxt;
   logic [15:0]      misr_nxt;
   logic             absorb;

   assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign misr_nxt = ({misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, rsp};
   // A pattern's valid bit reaches the end of the pipe in the cycle its response is on rsp.
   assign absorb   = vld_q[DLY-1];

   // Next-state, datapath and output-register logic for the whole run sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      pass_d  = pass_q;
      pat_d   = pat_q;
      vld_d   = '0;
      vld_d[0] = (state_q == RUN);
      for (int i = 1; i < int'(DLY); i++) begin
         vld_d[i] = vld_q[i-1];
      end
      if (absorb) begin
         misr_d = misr_nxt;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SEED;
            end
         end
         SEED: begin
            lfsr_d  = 8'h01;
            misr_d  = 16'hFFFF;
            cnt_d   = 16'h0000;
            pass_d  = 1'b0;
            vld_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            lfsr_d = lfsr_nxt;
            if (cnt_q == NPAT_LAST) begin
               cnt_d   = 16'h0000;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DRAIN: begin
            if (cnt_q == DLY_LAST) begin
               cnt_d   = 16'h0000;
               state_d = CMP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         CMP: begin
            pass_d  = (misr_q == exp);
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // pat is registered but must show each pattern during its own RUN cycle,
      // so it is loaded with the LFSR value being entered; held outside RUN, zero in IDLE.
      if (state_d == IDLE) begin
         pat_d = 8'h00;
      end else if (state_d == RUN) begin
         pat_d = lfsr_d;
      end
   end

   // State and datapath registers; cd aborts any run without a done pulse.
   always_ff @(posedge cp or posedge cd) begin
      if (cd) begin
         state_q <= IDLE;
         cnt_q   <= 16'h0000;
         lfsr_q  <= 8'h01;
         misr_q  <= 16'hFFFF;
         pat_q   <= 8'h00;
         pass_q  <= 1'b0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         pat_q   <= pat_d;
         pass_q  <= pass_d;
         vld_q   <= vld_d;
      end
   end

   assign pat  = pat_q;
   assign pass = pass_q;
   assign busy = (state_q == SEED) || (state_q == RUN) || (state_q == DRAIN) || (state_q == CMP);
   assign done = (state_q == DONE);
`ifdef SG13G2_BIST_SIG_OUT_EN
   assign sig  = misr_q;
`endif

endmodule

// File: tb/tb_sg13g2_cell_bist.sv
// Bench for sg13g2_cell_bist: instance a (NPAT=4, DLY=1, rsp = pat through one flop),
// instance b (NPAT=1, DLY=4, rsp = 8'hA5). Expected run results are queued at start
// and popped by a monitor on every done pulse.
module tb_sg13g2_cell_bist;

   localparam int NPAT_A = 4;
   localparam int DLY_A  = 1;
   localparam int NPAT_B = 1;
   localparam int DLY_B  = 4;
   localparam logic [31:0] PATS_A = 32'h08040201;
   localparam logic [31:0] PATS_B = 32'h00000001;

   logic        cp = 1'b0;
   logic        cd = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [15:0] exp_a = 16'h0000;
   logic [15:0] exp_b = 16'h0000;
   logic [7:0]  rsp_a = 8'h00;
   logic [7:0]  rsp_b = 8'hA5;
   logic [7:0]  pat_a, pat_b;
   logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic [15:0] sig_a, sig_b;

   typedef struct {
      logic        pass;
      int          len;
      logic [15:0] sig;
      int          gap;
      int          npat;
      logic [31:0] pats;
   } rec_t;

   rec_t q_a[$];
   rec_t q_b[$];

   int n_chk  = 0;
   int n_pass = 0;

   int          blen [2];
   int          idle [2];
   int          gapv [2];
   bit          pbusy[2];
   bit          pdone[2];
   logic [31:0] got  [2];

   always #5 cp = ~cp;

   // cells under test for instance a: one flop from pattern to response
   always @(posedge cp) rsp_a <= pat_a;

   sg13g2_cell_bist #(.NPAT(NPAT_A), .DLY(DLY_A)) u_a (
      .cp(cp), .cd(cd), .start(start_a), .exp(exp_a), .rsp(rsp_a),
      .pat(pat_a), .busy(busy_a), .done(done_a), .pass(pass_a)
`ifdef SG13G2_BIST_SIG_OUT_EN
      , .sig(sig_a)
`endif
   );

   sg13g2_cell_bist #(.NPAT(NPAT_B), .DLY(DLY_B)) u_b (
      .cp(cp), .cd(cd), .start(start_b), .exp(exp_b), .rsp(rsp_b),
      .pat(pat_b), .busy(busy_b), .done(done_b), .pass(pass_b)
`ifdef SG13G2_BIST_SIG_OUT_EN
      , .sig(sig_b)
`endif
   );

`ifndef SG13G2_BIST_SIG_OUT_EN
   assign sig_a = 16'h0000;
   assign sig_b = 16'h0000;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, req);
   endtask

   function automatic rec_t mk(input logic p, input int len, input logic [15:0] s,
                               input int gap, input int npat, input logic [31:0] pats);
      rec_t r;
      r.pass = p; r.len = len; r.sig = s; r.gap = gap; r.npat = npat; r.pats = pats;
      return r;
   endfunction

   task automatic mon_step(input int i, input logic busy, input logic done, input logic pass,
                           input logic [7:0] pat, input logic [15:0] sig);
      rec_t  e;
      string p;
      int    np;
      p  = (i == 0) ? "a" : "b";
      np = (i == 0) ? NPAT_A : NPAT_B;
      if (busy && !pbusy[i]) begin
         gapv[i] = idle[i];
         blen[i] = 0;
         got[i]  = 32'h0;
      end
      if (busy) begin
         if (blen[i] >= 1 && blen[i] <= np) got[i][8*(blen[i]-1) +: 8] = pat;
         blen[i]++;
         idle[i] = 0;
      end else begin
         idle[i]++;
      end
      if (done) begin
         if ((i == 0 ? q_a.size() : q_b.size()) == 0) begin
            chk({p, "_spurious_done"}, {31'h0, done}, 32'h0);
         end else begin
            if (i == 0) e = q_a.pop_front();
            else        e = q_b.pop_front();
            chk({p, "_pass"}, {31'h0, pass}, {31'h0, e.pass});
            chk({p, "_busy_len"}, blen[i], e.len);
            chk({p, "_done_shape"}, {30'h0, pbusy[i], pdone[i]}, 32'h2);
            chk({p, "_pats"}, got[i], e.pats);
            chk({p, "_pat_hold"}, {24'h0, pat}, {24'h0, e.pats[8*(e.npat-1) +: 8]});
            if (e.gap >= 0) chk({p, "_idle_gap"}, gapv[i], e.gap);
`ifdef SG13G2_BIST_SIG_OUT_EN
            chk({p, "_sig"}, {16'h0, sig}, {16'h0, e.sig});
`endif
         end
      end
      pbusy[i] = busy;
      pdone[i] = done;
   endtask

   // monitor: sample away from the rising edge and score each completed run
   always @(negedge cp) begin
      mon_step(0, busy_a, done_a, pass_a, pat_a, sig_a);
      mon_step(1, busy_b, done_b, pass_b, pat_b, sig_b);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge cp);
   endtask

   task automatic drain(input int bound);
      int c = 0;
      while ((q_a.size() + q_b.size()) != 0 && c < bound) begin
         @(negedge cp);
         c++;
      end
      chk("drain_timeout", q_a.size() + q_b.size(), 0);
   endtask

   initial begin
      int dcnt;
      int c;
      // reset state
      tick(1);
      chk("rst_pat", {24'h0, pat_a}, 32'h0);
      chk("rst_busy", {31'h0, busy_a}, 32'h0);
      chk("rst_done", {31'h0, done_a}, 32'h0);
      chk("rst_pass", {31'h0, pass_a}, 32'h0);
`ifdef SG13G2_BIST_SIG_OUT_EN
      chk("rst_sig", {16'h0, sig_a}, 32'h0000FFFF);
`endif
      cd = 1'b0;
      tick(1);

      // run 1: matching signature
      exp_a = 16'h0E1F;
      q_a.push_back(mk(1'b1, 7, 16'h0E1F, -1, NPAT_A, PATS_A));
      start_a = 1'b1; tick(1); start_a = 1'b0;
      chk("a_start_busy", {31'h0, busy_a}, 32'h1);
      drain(40); tick(2);
      chk("a_idle_pat", {24'h0, pat_a}, 32'h0);
      chk("a_pass_held", {31'h0, pass_a}, 32'h1);

      // run 2: off-by-one expected signature
      exp_a = 16'h0E1E;
      q_a.push_back(mk(1'b0, 7, 16'h0E1F, -1, NPAT_A, PATS_A));
      start_a = 1'b1; tick(1); start_a = 1'b0;
      drain(40); tick(2);
      chk("a_fail_held", {31'h0, pass_a}, 32'h0);

      // run 3: a second start pulse during RUN must be ignored
      exp_a = 16'h0E1F;
      q_a.push_back(mk(1'b1, 7, 16'h0E1F, -1, NPAT_A, PATS_A));
      start_a = 1'b1; tick(1); start_a = 1'b0;
      tick(2);
      start_a = 1'b1; tick(1); start_a = 1'b0;
      drain(40); tick(10);
      chk("a_no_rerun", {31'h0, busy_a}, 32'h0);

      // runs 4 and 5: start held high, one IDLE cycle between runs
      q_a.push_back(mk(1'b1, 7, 16'h0E1F, -1, NPAT_A, PATS_A));
      q_a.push_back(mk(1'b1, 7, 16'h0E1F, 2, NPAT_A, PATS_A));
      start_a = 1'b1;
      dcnt = 0; c = 0;
      while (dcnt < 2 && c < 100) begin
         tick(1); c++;
         if (done_a) dcnt++;
      end
      start_a = 1'b0;
      chk("a_two_dones", dcnt, 2);
      drain(10); tick(3);
      chk("a_held_stop", {31'h0, busy_a}, 32'h0);

      // asynchronous reset clears a held pass
      #2 cd = 1'b1;
      #1 chk("a_rst_pass_async", {31'h0, pass_a}, 32'h0);
      tick(1); cd = 1'b0; tick(1);

      // reset mid-RUN: outputs clear before any clock edge, no done afterwards
      start_a = 1'b1; tick(1); start_a = 1'b0;
      tick(2);
      chk("a_run_pat", {24'h0, pat_a}, 32'h2);
      #2 cd = 1'b1;
      #1;
      chk("a_abort_pat", {24'h0, pat_a}, 32'h0);
      chk("a_abort_busy", {31'h0, busy_a}, 32'h0);
      chk("a_abort_done", {31'h0, done_a}, 32'h0);
      chk("a_abort_pass", {31'h0, pass_a}, 32'h0);
`ifdef SG13G2_BIST_SIG_OUT_EN
      chk("a_abort_sig", {16'h0, sig_a}, 32'h0000FFFF);
`endif
      tick(2); cd = 1'b0; tick(20);
      chk("a_wait_idle", {31'h0, busy_a}, 32'h0);

      // recovery run after the abort
      q_a.push_back(mk(1'b1, 7, 16'h0E1F, -1, NPAT_A, PATS_A));
      start_a = 1'b1; tick(1); start_a = 1'b0;
      drain(40); tick(2);

      // instance b: single pattern, deep response delay, one absorb
      exp_b = 16'hEF7A;
      q_b.push_back(mk(1'b1, 1 + NPAT_B + DLY_B + 1, 16'hEF7A, -1, NPAT_B, PATS_B));
      start_b = 1'b1; tick(1); start_b = 1'b0;
      drain(40); tick(2);
      exp_b = 16'hEF7B;
      q_b.push_back(mk(1'b0, 1 + NPAT_B + DLY_B + 1, 16'hEF7A, -1, NPAT_B, PATS_B));
      start_b = 1'b1; tick(1); start_b = 1'b0;
      drain(40); tick(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
